lcd_controller: RTL and testbench

//  HD44780-compatible character LCD driver, 4-bit bus, write-only (R/W tied low off-chip).

---
 rtl/lcd_controller.sv | 212 +++++++++++++++++++++
 tb/tb_lcd_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// lcd_controller: HD44780 4-bit write-only driver with built-in power-on init.
// Option: define LCD_CURSOR_EN for cursor and blink on at init.
// Revision: 1.0
//------------------------------------------------------------------------------
module lcd_controller #(
  parameter int T_POWERUP = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_SETUP   = 2,
  parameter int T_E_HIGH  = 12,
  parameter int T_NIB_GAP = 50,
  parameter int T_CMD     = 2000,
  parameter int T_LONG    = 82000
) (
  input  logic       clkLcd,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       rs,
  input  logic       send,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [3:0] lcd_data
);

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = mx(mx(mx(T_POWERUP, T_INIT1), mx(T_INIT2, T_SETUP)),
                            mx(mx(T_E_HIGH, T_NIB_GAP), mx(T_CMD, T_LONG)));
  localparam int CNT_W = ($clog2(T_MAX + 1) > 20) ? $clog2(T_MAX + 1) : 20;

`ifdef LCD_CURSOR_EN
  localparam logic [7:0] DISP_CTRL = 8'h0F;
`else
  localparam logic [7:0] DISP_CTRL = 8'h0C;
`endif

  // A state lasting t cycles is entered with t-1 loaded into the down-counter.
  function automatic logic [CNT_W-1:0] ld(input int t);
    return (t > 1) ? CNT_W'(t - 1) : '0;
  endfunction

  typedef enum logic [3:0] {
    POWERUP   = 4'd0,
    INIT_NIB  = 4'd1,
    INIT_WAIT = 4'd2,
    INIT_BYTE = 4'd3,
    IDLE      = 4'd4,
    SETUP     = 4'd5,
    E_HIGH    = 4'd6,
    NIB_GAP   = 4'd7,
    SETTLE    = 4'd8
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       init_step;
  logic             init_done;
  logic [7:0]       byte_q;
  logic             byte_rs;
  logic             nib_idx;

  logic [3:0]       init_nib;
  logic [CNT_W-1:0] init_wait;
  logic [7:0]       init_byte;
  logic             long_settle;
  logic             nibble_only;

  // Steps 0..3 are lone 8-bit-mode nibbles, steps 4..7 are full bytes.
  always_comb begin
    init_nib = (init_step == 3'd3) ? 4'h2 : 4'h3;
    case (init_step[1:0])
      2'd0:    init_wait = ld(T_INIT1);
      2'd1:    init_wait = ld(T_INIT2);
      default: init_wait = ld(T_CMD);
    endcase
    case (init_step[1:0])
      2'd0:    init_byte = 8'h28;
      2'd1:    init_byte = DISP_CTRL;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
    long_settle = !byte_rs && (byte_q[7:2] == 6'd0);
    nibble_only = !init_done && !init_step[2];
  end

  assign busy = (state != IDLE) | send;

  always_ff @(posedge clkLcd or posedge reset) begin
    if (reset) begin
      state     <= POWERUP;
      cnt       <= ld(T_POWERUP);
      init_step <= 3'd0;
      init_done <= 1'b0;
      byte_q    <= 8'h00;
      byte_rs   <= 1'b0;
      nib_idx   <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_data  <= 4'h0;
    end else begin
      case (state)
        POWERUP: begin
          if (cnt == '0) state <= INIT_NIB;
          else           cnt   <= cnt - 1'b1;
        end

        INIT_NIB: begin
          lcd_rs   <= 1'b0;
          lcd_data <= init_nib;
          cnt      <= ld(T_SETUP);
          state    <= SETUP;
        end

        INIT_WAIT: begin
          if (cnt == '0) begin
            init_step <= init_step + 3'd1;
            state     <= (init_step == 3'd3) ? INIT_BYTE : INIT_NIB;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        INIT_BYTE: begin
          byte_q   <= init_byte;
          byte_rs  <= 1'b0;
          lcd_rs   <= 1'b0;
          lcd_data <= init_byte[7:4];
          nib_idx  <= 1'b0;
          cnt      <= ld(T_SETUP);
          state    <= SETUP;
        end

        IDLE: begin
          if (send) begin
            byte_q   <= data_in;
            byte_rs  <= rs;
            lcd_rs   <= rs;
            lcd_data <= data_in[7:4];
            nib_idx  <= 1'b0;
            cnt      <= ld(T_SETUP);
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == '0) begin
            lcd_e <= 1'b1;
            cnt   <= ld(T_E_HIGH);
            state <= E_HIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        E_HIGH: begin
          if (cnt == '0) begin
            lcd_e <= 1'b0;
            if (nibble_only) begin
              cnt   <= init_wait;
              state <= INIT_WAIT;
            end else if (!nib_idx) begin
              cnt   <= ld(T_NIB_GAP);
              state <= NIB_GAP;
            end else begin
              cnt   <= long_settle ? ld(T_LONG) : ld(T_CMD);
              state <= SETTLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        NIB_GAP: begin
          if (cnt == '0) begin
            nib_idx  <= 1'b1;
            lcd_data <= byte_q[3:0];
            cnt      <= ld(T_SETUP);
            state    <= SETUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        SETTLE: begin
          if (cnt == '0) begin
            if (init_done) begin
              state <= IDLE;
            end else if (init_step == 3'd7) begin
              init_done <= 1'b1;
              init_step <= 3'd0;
              state     <= IDLE;
            end else begin
              init_step <= init_step + 3'd1;
              state     <= INIT_BYTE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= POWERUP;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_controller.sv
`default_nettype none
// tb_lcd_controller: randomized bench; the LCD bus is decoded into a nibble
// stream and compared with a byte-level reference model plus timing rules.
module tb_lcd_controller;

  localparam int T_POWERUP = 100;
  localparam int T_INIT1   = 40;
  localparam int T_INIT2   = 20;
  localparam int T_SETUP   = 2;
  localparam int T_E_HIGH  = 3;
  localparam int T_NIB_GAP = 4;
  localparam int T_CMD     = 10;
  localparam int T_LONG    = 30;

`ifdef LCD_CURSOR_EN
  localparam logic [7:0] DISP = 8'h0F;
`else
  localparam logic [7:0] DISP = 8'h0C;
`endif

  logic       clkLcd  = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       rs      = 1'b0;
  logic       send    = 1'b0;
  logic       busy;
  logic       lcd_rs;
  logic       lcd_e;
  logic [3:0] lcd_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [4:0] obs_q[$];
  logic [4:0] exp_q[$];

  lcd_controller #(
    .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_SETUP(T_SETUP),
    .T_E_HIGH(T_E_HIGH), .T_NIB_GAP(T_NIB_GAP), .T_CMD(T_CMD), .T_LONG(T_LONG)
  ) dut (
    .clkLcd(clkLcd), .reset(reset), .data_in(data_in), .rs(rs), .send(send),
    .busy(busy), .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_data(lcd_data)
  );

  always #5 clkLcd = ~clkLcd;
  always @(posedge clkLcd) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: captures each E-strobed nibble and checks strobe timing.
  logic       prev_e    = 1'b0;
  logic [4:0] prev_bus  = 5'h0;
  int         last_chg  = 0;
  int         rise_cyc  = 0;
  int         fall_cyc  = 0;

  always @(negedge clkLcd) begin
    if (reset) begin
      prev_e   = 1'b0;
      prev_bus = 5'h0;
    end else begin
      if ({lcd_rs, lcd_data} != prev_bus) begin
        check("bus_change_near_e", {31'd0, lcd_e | prev_e}, 32'd0);
        last_chg = cyc;
        prev_bus = {lcd_rs, lcd_data};
      end
      if (lcd_e && !prev_e) begin
        check("setup_time_ok", {31'd0, (cyc - last_chg) >= T_SETUP}, 32'd1);
        obs_q.push_back({lcd_rs, lcd_data});
        rise_cyc = cyc;
      end
      if (!lcd_e && prev_e) begin
        check("e_high_width", cyc - rise_cyc, T_E_HIGH);
        fall_cyc = cyc;
      end
      prev_e = lcd_e;
    end
  end

  // Reference model: a byte is two nibbles; settle length from the command rule.
  function automatic void exp_byte(input logic r, input logic [7:0] b);
    exp_q.push_back({r, b[7:4]});
    exp_q.push_back({r, b[3:0]});
  endfunction

  function automatic int exp_settle(input logic r, input logic [7:0] b);
    return (!r && b < 8'd4) ? T_LONG : T_CMD;
  endfunction

  task automatic expect_init();
    logic [3:0] nibs [4];
    nibs = '{4'h3, 4'h3, 4'h3, 4'h2};
    foreach (nibs[i]) exp_q.push_back({1'b0, nibs[i]});
    exp_byte(1'b0, 8'h28);
    exp_byte(1'b0, DISP);
    exp_byte(1'b0, 8'h06);
    exp_byte(1'b0, 8'h01);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check(tag, {27'd0, obs_q[i]}, {27'd0, exp_q[i]});
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input int budget, output int idle_cyc, output bit ok);
    ok = 1'b0;
    idle_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clkLcd);
      if (!busy) begin
        ok = 1'b1;
        idle_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_e_high(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clkLcd);
      if (lcd_e) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Single-cycle send pulse issued from a negedge while the DUT is idle.
  task automatic send_byte(input logic r, input logic [7:0] d);
    rs = r;
    data_in = d;
    send = 1'b1;
    #1;
    check("busy_follows_send", {31'd0, busy}, 32'd1);
    @(posedge clkLcd);
    #1;
    send = 1'b0;
    data_in = 8'($urandom);
    rs = 1'($urandom);
  endtask

  task automatic byte_round(input string tag, input logic r, input logic [7:0] d);
    int  idle_cyc;
    bit  ok;
    send_byte(r, d);
    exp_byte(r, d);
    wait_idle(300, idle_cyc, ok);
    check({tag, "_done"}, {31'd0, ok}, 32'd1);
    compare_stream(tag);
    check({tag, "_settle"}, idle_cyc - fall_cyc, exp_settle(r, d));
  endtask

  initial begin
    int         idle_cyc;
    bit         ok;
    bit         b;
    logic       r;
    logic [7:0] d;
    int         k;
    logic [8:0] reqs [3];

    // Reset state
    repeat (3) @(negedge clkLcd);
    check("rst_lcd_e", {31'd0, lcd_e}, 32'd0);
    check("rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
    check("rst_lcd_data", {28'd0, lcd_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;

    // Power-on init: busy until the whole sequence has gone out
    expect_init();
    wait_idle(3000, idle_cyc, ok);
    check("init_done", {31'd0, ok}, 32'd1);
    compare_stream("init_nibbles");
    check("init_clear_settle", idle_cyc - fall_cyc, T_LONG);

    // Directed data and clear bytes
    byte_round("data_41", 1'b1, 8'h41);
    byte_round("cmd_clear", 1'b0, 8'h01);

    // Randomized bytes with random idle gaps
    for (int i = 0; i < 16; i++) begin
      r = 1'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        r = 1'b0;
        d = 8'($urandom_range(1, 3));
      end
      repeat ($urandom_range(0, 3)) @(negedge clkLcd);
      byte_round("rand_byte", r, d);
    end

    // Registered requester: samples busy, updates send just after the clock edge
    reqs = '{{1'b0, 8'h80}, {1'b1, 8'h41}, {1'b1, 8'h42}};
    foreach (reqs[i]) exp_byte(reqs[i][8], reqs[i][7:0]);
    k = 0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clkLcd);
      b = busy;
      @(posedge clkLcd);
      #1;
      if (!b && k < 3) begin
        send = 1'b1;
        rs = reqs[k][8];
        data_in = reqs[k][7:0];
        k++;
      end else begin
        send = 1'b0;
      end
      if (k == 3 && !send && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    send = 1'b0;
    check("req_done", {31'd0, ok}, 32'd1);
    repeat (40) @(negedge clkLcd);
    compare_stream("req_stream");

    // send during a transfer is ignored
    d = 8'h5A;
    send_byte(1'b1, d);
    exp_byte(1'b1, d);
    wait_e_high(100, ok);
    check("mid_e_seen", {31'd0, ok}, 32'd1);
    rs = 1'b0;
    data_in = 8'hFF;
    send = 1'b1;
    @(posedge clkLcd);
    #1;
    send = 1'b0;
    wait_idle(300, idle_cyc, ok);
    check("mid_done", {31'd0, ok}, 32'd1);
    check("mid_settle", idle_cyc - fall_cyc, T_CMD);
    repeat (40) @(negedge clkLcd);
    compare_stream("mid_ignore");

    // Reset while E is high aborts and restarts init
    send_byte(1'b1, 8'($urandom));
    wait_e_high(100, ok);
    check("abort_e_seen", {31'd0, ok}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_lcd_e", {31'd0, lcd_e}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd1);
    check("abort_lcd_data", {28'd0, lcd_data}, 32'd0);
    repeat (2) @(negedge clkLcd);
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    expect_init();
    wait_idle(3000, idle_cyc, ok);
    check("reinit_done", {31'd0, ok}, 32'd1);
    compare_stream("reinit_nibbles");
    check("reinit_clear_settle", idle_cyc - fall_cyc, T_LONG);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
